// File: rtl/models_pack.sv
// Shared definitions for the 4-channel output serializer tile.
// Contents: mode encodings, shifter FSM states, ConfigBits field positions
// and a helper that selects the bit driven on O0 for a given bit slot.
package models_pack;

  typedef enum logic [1:0] {
    MODE_COMB    = 2'b00,
    MODE_REG     = 2'b01,
    MODE_SER_LSB = 2'b10,
    MODE_SER_MSB = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_e;

  // ConfigBits layout: [1:0] mode, [3:2] DIV (bit hold time minus one).
  // Bit 0 of the mode doubles as the serial order (1 = MSB first) and
  // bit 1 selects the serial modes.
  localparam int CFG_ORDER_BIT  = 0;
  localparam int CFG_SERIAL_BIT = 1;
  localparam int CFG_DIV_LO     = 2;
  localparam int CFG_DIV_HI     = 3;

  // Bit of the word sent in slot idx; MSB-first walks 3,2,1,0 (= ~idx).
  function automatic logic word_bit(input logic [3:0] word,
                                    input logic       msb_first,
                                    input logic [1:0] idx);
    return msb_first ? word[~idx] : word[idx];
  endfunction

endpackage

// File: rtl/out_ser4_shifter.sv
// 4-bit word serializer with valid/ready handshake.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   en_i            serial mode selected; low aborts any word in flight
//   msb_first_i     order, latched at accept
//   div_i           each bit held div_i+1 cycles, latched at accept
//   valid_i/ready_o word handshake; data_i = {I3,I2,I1,I0}
//   ser_o           registered {busy, strobe, frame, data}
module out_ser4_shifter
  import models_pack::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic       msb_first_i,
  input  logic [1:0] div_i,
  input  logic       valid_i,
  output logic       ready_o,
  input  logic [3:0] data_i,
  output logic [3:0] ser_o
);

  ser_state_e state_q;
  logic [3:0] word_q;
  logic       order_q;
  logic [1:0] divl_q;
  logic [1:0] bit_q;
  logic [1:0] div_q;
  logic [3:0] out_q;
  logic       last_cycle;
  logic       accept;
  logic [1:0] bit_inc;

  assign last_cycle = (state_q == ST_SHIFT) && (bit_q == 2'd3) && (div_q == divl_q);
  // Ready in idle, and in the final cycle of a word so words can abut.
  assign ready_o    = en_i && ((state_q == ST_IDLE) || last_cycle);
  assign accept     = valid_i && ready_o;
  assign bit_inc    = bit_q + 2'd1;
  assign ser_o      = out_q;

  // Outputs are registered alongside the state, so every branch sets the
  // value the pins must show during the cycle that follows the edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      word_q  <= 4'b0;
      order_q <= 1'b0;
      divl_q  <= 2'b0;
      bit_q   <= 2'b0;
      div_q   <= 2'b0;
      out_q   <= 4'b0;
    end else if (!en_i) begin
      state_q <= ST_IDLE;
      bit_q   <= 2'b0;
      div_q   <= 2'b0;
      out_q   <= 4'b0;
    end else if (accept) begin
      state_q <= ST_SHIFT;
      word_q  <= data_i;
      order_q <= msb_first_i;
      divl_q  <= div_i;
      bit_q   <= 2'b0;
      div_q   <= 2'b0;
      out_q   <= {3'b111, word_bit(data_i, msb_first_i, 2'd0)};
    end else if (state_q == ST_SHIFT) begin
      if (last_cycle) begin
        state_q <= ST_IDLE;
        bit_q   <= 2'b0;
        div_q   <= 2'b0;
        out_q   <= 4'b0;
      end else if (div_q == divl_q) begin
        div_q <= 2'b0;
        bit_q <= bit_inc;
        out_q <= {3'b111, word_bit(word_q, order_q, bit_inc)};
      end else begin
        div_q    <= div_q + 2'd1;
        out_q[2] <= 1'b0;  // strobe only on the first cycle of a bit
      end
    end
  end

endmodule

// File: rtl/out_serializer4_frame_config.sv
// Fabric-to-pad output tile: 4 fabric signals to 4 pins.
// Ports:
//   UserCLK, UserRSTn  clock, asynchronous active-low reset
//   I0..I3             fabric data; serial word is {I3,I2,I1,I0}
//   I_valid, I_ready   word handshake (serial modes only)
//   O0..O3             pins; serial modes give O0 data, O1 frame,
//                      O2 bit strobe, O3 busy
//   ConfigBits         [1:0] mode, [3:2] DIV
module out_serializer4_frame_config
  import models_pack::*;
#(
  parameter int NoConfigBits = 4
) (
  input  logic                    UserCLK,
  input  logic                    UserRSTn,
  input  logic                    I0,
  input  logic                    I1,
  input  logic                    I2,
  input  logic                    I3,
  input  logic                    I_valid,
  output logic                    I_ready,
  output logic                    O0,
  output logic                    O1,
  output logic                    O2,
  output logic                    O3,
  input  logic [NoConfigBits-1:0] ConfigBits
);

  mode_e      mode;
  logic [3:0] din;
  logic [3:0] pass_q;
  logic [3:0] ser_out;
  logic       ser_ready;
  logic [3:0] dout;

  assign mode = mode_e'(ConfigBits[CFG_SERIAL_BIT:CFG_ORDER_BIT]);
  assign din  = {I3, I2, I1, I0};

  always_ff @(posedge UserCLK or negedge UserRSTn) begin
    if (!UserRSTn) begin
      pass_q <= 4'b0;
    end else begin
      pass_q <= din;
    end
  end

  out_ser4_shifter u_shifter (
    .clk_i       (UserCLK),
    .rst_ni      (UserRSTn),
    .en_i        (ConfigBits[CFG_SERIAL_BIT]),
    .msb_first_i (ConfigBits[CFG_ORDER_BIT]),
    .div_i       (ConfigBits[CFG_DIV_HI:CFG_DIV_LO]),
    .valid_i     (I_valid),
    .ready_o     (ser_ready),
    .data_i      (din),
    .ser_o       (ser_out)
  );

  // Mode 00 bypasses every register, so pins track I even under reset.
  always_comb begin
    dout    = ser_out;
    I_ready = 1'b1;
    case (mode)
      MODE_COMB: dout = din;
      MODE_REG:  dout = pass_q;
      default: begin
        dout    = ser_out;
        I_ready = ser_ready;
      end
    endcase
  end

  assign {O3, O2, O1, O0} = dout;

endmodule
